// File: rtl/result_display_if.sv
// Result handshake bundle between the ULA and the result display unit.
//   result_valid  - result_data / result_opcode are valid this cycle
//   result_data   - ULA result value (WIDTH bits)
//   result_opcode - opcode that produced the result
//   ready         - high when the display unit will accept a capture
// master: producer side (ULA); slave: result_display.
interface result_display_if #(
  parameter int WIDTH = 8
) ();
  logic             result_valid;
  logic [WIDTH-1:0] result_data;
  logic [3:0]       result_opcode;
  logic             ready;

  modport master (
    output result_valid,
    output result_data,
    output result_opcode,
    input  ready
  );

  modport slave (
    input  result_valid,
    input  result_data,
    input  result_opcode,
    output ready
  );
endinterface

// File: rtl/result_display.sv
// result_display: captures ULA results with their opcode into a small
// circular history, converts the displayed entry to three decimal digits
// with a one-bit-per-cycle double-dabble engine, and drives the 7-segment
// displays (active-low, gfedcba) and the green LEDs.
// Ports:
//   clock, resetn   - clock and synchronous active-low reset
//   bus (slave)     - result_valid/result_data/result_opcode in, ready out
//   advance         - debounced key, each rising edge steps to an older entry
//   count           - number of valid history entries (saturates at DEPTH)
//   hex0..hex2      - units/tens/hundreds digit of the displayed entry
//   hex3            - opcode of the displayed entry (hex digit)
//   ledg            - raw bits of the displayed entry, zero-extended
// Optional build macro SIGNED_DISPLAY_EN: data is two's complement, the
// magnitude is displayed and hex3 shows '-' for negatives (blank otherwise).
module result_display #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  result_display_if.slave          bus,
  input  logic                     advance,
  output logic [$clog2(DEPTH):0]   count,
  output logic [6:0]               hex0,
  output logic [6:0]               hex1,
  output logic [6:0]               hex2,
  output logic [6:0]               hex3,
  output logic [7:0]               ledg
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int SW    = WIDTH + 12;          // {hundreds, tens, units, binary}
  localparam int STEPW = $clog2(WIDTH) + 1;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic {IDLE, CONV} state_t;
  state_t state_reg, state_next;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [WIDTH+3:0] hist_mem [DEPTH];         // {opcode, data}
  logic [PW-1:0]    wr_ptr_reg, view_reg;
  logic [CW-1:0]    count_reg;
  logic             adv_reg;
  logic [SW-1:0]    dd_reg;
  logic [STEPW-1:0] step_reg;
  logic [6:0]       hex3_pend_reg;            // hex3 code of the entry being converted
  logic [7:0]       ledg_pend_reg;
  logic [6:0]       hex0_reg, hex1_reg, hex2_reg, hex3_reg;
  logic [7:0]       ledg_reg;

  logic             adv_edge, capture, step_back, last_step;
  logic [PW-1:0]    oldest, newest, view_prev;
  logic [WIDTH+3:0] sel_entry;
  logic [WIDTH-1:0] sel_data, sel_mag;
  logic [3:0]       sel_op;
  logic [6:0]       sel_hex3;
  logic [15:0]      sel_ext;
  logic [SW-1:0]    dd_adj, dd_shift;

  assign bus.ready = (state_reg == IDLE);
  assign adv_edge  = advance & ~adv_reg;
  assign capture   = bus.result_valid && (state_reg == IDLE);
  // A capture in the same cycle wins over the advance edge.
  assign step_back = adv_edge && (state_reg == IDLE) && !bus.result_valid && (count_reg != '0);
  assign last_step = (step_reg == STEPW'(WIDTH - 1));

  // Oldest valid entry sits count entries behind the write pointer; when the
  // buffer is full the truncated count is 0, so oldest == wr_ptr as required.
  assign oldest    = wr_ptr_reg - count_reg[PW-1:0];
  assign newest    = wr_ptr_reg - PW'(1);
  assign view_prev = (view_reg == oldest) ? newest : view_reg - PW'(1);

  // Memory is read asynchronously so the advance edge can start a conversion
  // in the same cycle, like a capture does.
  assign sel_entry = capture ? {bus.result_opcode, bus.result_data} : hist_mem[view_prev];
  assign sel_data  = sel_entry[WIDTH-1:0];
  assign sel_op    = sel_entry[WIDTH+3:WIDTH];
  assign sel_ext   = 16'(sel_data);

`ifdef SIGNED_DISPLAY_EN
  // Most negative value maps onto itself, which reads correctly as unsigned.
  assign sel_mag  = sel_data[WIDTH-1] ? (~sel_data + WIDTH'(1)) : sel_data;
  assign sel_hex3 = sel_data[WIDTH-1] ? 7'h3F : BLANK;
`else
  assign sel_mag  = sel_data;
  assign sel_hex3 = seg7(sel_op);
`endif

  // Double-dabble step: +3 on every BCD nibble >= 5, then shift left by one.
  assign dd_adj[WIDTH-1:0] = dd_reg[WIDTH-1:0];
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bcd_adj
      logic [3:0] nib;
      assign nib = dd_reg[WIDTH+4*gi +: 4];
      assign dd_adj[WIDTH+4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate
  assign dd_shift = {dd_adj[SW-2:0], 1'b0};

  always_ff @(posedge clock) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (capture || step_back) state_next = CONV;
      CONV: if (last_step)            state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn && capture) hist_mem[wr_ptr_reg] <= {bus.result_opcode, bus.result_data};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      adv_reg       <= 1'b0;
      wr_ptr_reg    <= '0;
      view_reg      <= '0;
      count_reg     <= '0;
      dd_reg        <= '0;
      step_reg      <= '0;
      hex3_pend_reg <= BLANK;
      ledg_pend_reg <= '0;
      hex0_reg      <= BLANK;
      hex1_reg      <= BLANK;
      hex2_reg      <= BLANK;
      hex3_reg      <= BLANK;
      ledg_reg      <= '0;
    end else begin
      adv_reg <= advance;
      if (capture) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
        view_reg   <= wr_ptr_reg;
        if (count_reg != CW'(DEPTH)) count_reg <= count_reg + CW'(1);
      end else if (step_back) begin
        view_reg <= view_prev;
      end

      if (capture || step_back) begin
        dd_reg        <= {12'b0, sel_mag};
        step_reg      <= '0;
        hex3_pend_reg <= sel_hex3;
        ledg_pend_reg <= sel_ext[7:0];
      end else if (state_reg == CONV) begin
        dd_reg   <= dd_shift;
        step_reg <= step_reg + STEPW'(1);
        if (last_step) begin
          hex0_reg <= seg7(dd_shift[WIDTH   +: 4]);
          hex1_reg <= seg7(dd_shift[WIDTH+4 +: 4]);
          hex2_reg <= seg7(dd_shift[WIDTH+8 +: 4]);
          hex3_reg <= hex3_pend_reg;
          ledg_reg <= ledg_pend_reg;
        end
      end
    end
  end

  assign count = count_reg;
  assign hex0  = hex0_reg;
  assign hex1  = hex1_reg;
  assign hex2  = hex2_reg;
  assign hex3  = hex3_reg;
  assign ledg  = ledg_reg;
endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Output-side unit of the simple processor: captures each result word produced by the ULA together with its opcode.
- Keeps a short history of captured results and converts the displayed entry to decimal with a sequential double-dabble engine.
- Drives HEX0..HEX3 and LEDG so the operator can read the result and step back through earlier ones with a key.

Parameters:
- WIDTH, 8, result data width in bits; the BCD engine is sized for 3 decimal digits, so WIDTH <= 9.
- DEPTH, 4, number of history entries; must be a power of 2, minimum 2.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  synchronous reset, active-low.
- result_valid  input  1  result_data and result_opcode are valid this cycle.
- result_data  input  WIDTH  ULA result value.
- result_opcode  input  4  opcode that produced the result.
- advance  input  1  step-back request, active-high level from a debounced key.
- ready  output  1  high when a capture will be accepted.
- count  output  $clog2(DEPTH)+1  number of valid history entries.
- hex0  output  7  units digit, active-low, bit6..bit0 = g..a.
- hex1  output  7  tens digit.
- hex2  output  7  hundreds digit.
- hex3  output  7  opcode of the displayed entry as a hex digit 0-F.
- ledg  output  8  raw binary of the displayed entry, zero-extended.

Behaviour:
- Reset (resetn low at an edge):
  - hex0..hex3 = 7'h7F (blank), ledg = 0, count = 0, ready = 1.
  - History is invalidated, FSM goes to IDLE, advance edge detector is cleared.
  - A conversion in progress is abandoned.
- Capture:
  - A result is accepted at any edge where result_valid = 1 and ready = 1.
  - The pair {opcode, data} is written into a circular buffer at the write pointer, and the write pointer increments mod DEPTH.
  - count increments and saturates at DEPTH; when the buffer is full, the oldest entry is overwritten.
  - The view pointer moves to the newly written (newest) entry.
- Advance:
  - Rising edge of advance is detected internally against a registered copy; holding the key counts as one step.
  - On an edge, with the FSM in IDLE and count > 0, the view pointer moves to the next older entry.
  - From the oldest valid entry it wraps to the newest.
  - If count = 0 the edge is ignored.
  - An edge detected while the FSM is in CONV is dropped, not queued.
- Simultaneous events: if result_valid and an advance edge occur in the same IDLE cycle, the capture wins and the advance is dropped.
- FSM states:
  - IDLE: ready = 1.
  - CONV: ready = 0.
  - IDLE -> CONV on a capture or an accepted advance. The shift register is loaded with the selected data, BCD digits are cleared, and the step counter is set to 0.
  - CONV performs one double-dabble step per cycle: each BCD nibble >= 5 gets +3, then the whole register shifts left by one. This runs for WIDTH steps.
  - On the edge that performs the last step, hex0..hex2, hex3 and ledg all update together, and the FSM returns to IDLE.
- Latency:
  - A capture at edge E gives new outputs at edge E+WIDTH (E+8 by default).
  - ready is low from E through E+WIDTH and high again in the following cycle.
- Leading zeros are shown as '0' (e.g. value 5 displays 0 0 5).
- Segment codes, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06, F=0E.
- Outputs stay stable between conversions. hex and ledg hold the last completed conversion.

Optional Feature:
- Macro: SIGNED_DISPLAY_EN.
- When defined:
  - result_data is treated as two's complement.
  - The magnitude is converted; -128 displays as 128.
  - hex3 shows '-' (7'h3F) for negative values and blank (7'h7F) otherwise; the opcode is not displayed.
  - ledg still shows the raw bits.
- When undefined: data is unsigned and hex3 shows the opcode.

Test Plan:
- Reset: hold resetn low for 2 cycles with result_valid high -> all hex = 7F, ledg = 0, count = 0, ready = 1, nothing captured.
- Single capture: data 173, opcode 2 -> ready low for 8 cycles; after edge E+8, hex2 = 79, hex1 = 78, hex0 = 30, hex3 = 24, ledg = 8'hAD.
- History wrap: capture 10, 20, 30, 40, 50 (waiting for ready each time) -> count = 4, display 050. Then five advance pulses -> displays 040, 030, 020, 050, 040.
- Busy and simultaneous events:
  - An advance edge during CONV -> ignored, display unchanged.
  - result_valid together with an advance edge in IDLE -> capture taken, view is the newest entry.
  - result_valid while ready = 0 -> not captured, count unchanged.
- Reset mid-conversion: resetn low at E+4 -> outputs blank, count = 0, ready = 1 next cycle. An advance edge afterwards is ignored because count = 0.
- SIGNED_DISPLAY_EN: data 8'hFF -> hex3 = 3F, digits 001. Data 8'h80 -> '-' with 128. Data 8'h7F -> hex3 = 7F, digits 127.
